mult_div_unit: RTL and testbench

//  Execute-stage multiply/divide unit: owns the HI/LO registers and runs mult, multu, div and divu
//  as multi-cycle operations. Handles mthi/mtlo writes and drives xaluout for mfhi/mflo.
//  Its xaluout feeds the E-stage ALU-result select, which picks xaluout when xaluop is 7 or 8.
//  Its busy output goes to the hazard unit, which stalls D-stage md instructions while busy.

---
 rtl/mult_div_unit.sv | 132 +++++++++++++
 tb/tb_mult_div_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. mult/multu/div/divu run as multi-cycle
// operations; mthi/mtlo write directly and mfhi/mflo read through xaluout.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  xaluop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] xaluout
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     a_q, b_q, hi_q, lo_q;
  logic [3:0]      op_q;
  logic            busy_q;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        mag_a, mag_b, quo_u, rem_u, quo, rem;
  logic               is_sdiv, neg_quo, neg_rem;
  logic [31:0]        res_hi, res_lo;
  logic               res_wr;

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow hazards.
  always_comb begin
    prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    is_sdiv = (op_q == OpDiv);
    mag_a   = (is_sdiv && a_q[31]) ? (~a_q + 32'd1) : a_q;
    mag_b   = (is_sdiv && b_q[31]) ? (~b_q + 32'd1) : b_q;
    quo_u   = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
    rem_u   = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;
    neg_quo = is_sdiv && (a_q[31] ^ b_q[31]);
    neg_rem = is_sdiv && a_q[31];
    quo     = neg_quo ? (~quo_u + 32'd1) : quo_u;
    rem     = neg_rem ? (~rem_u + 32'd1) : rem_u;

    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    case (op_q)
      OpMult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      OpMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      OpDiv, OpDivu: begin
        res_hi = rem;
        res_lo = quo;
        res_wr = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (xaluop == OpMult || xaluop == OpMultu || xaluop == OpDiv || xaluop == OpDivu) begin
              a_q     <= a;
              b_q     <= b;
              op_q    <= xaluop;
              cnt_q   <= (xaluop == OpMult || xaluop == OpMultu) ? CntW'(MULT_CYCLES)
                                                                 : CntW'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= StRun;
            end else if (xaluop == OpMthi) begin
              hi_q <= a;
            end else if (xaluop == OpMtlo) begin
              lo_q <= a;
            end
          end
        end
        StRun: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            if (res_wr) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign xaluout = (xaluop == OpMfhi) ? hi_q : (xaluop == OpMflo) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops checked
// against a 64-bit arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  xaluop = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, xaluout;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mult_div_unit #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .xaluop(xaluop), .start(start),
    .busy(busy), .hi(hi), .lo(lo), .xaluout(xaluout)
  );

  always #5 clk = ~clk;

  // Reference: HI/LO after an operation, from plain 64-bit arithmetic.
  task automatic model_exec(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    case (op)
      4'd1: begin q = sa * sb; m_hi = q[63:32]; m_lo = q[31:0]; end
      4'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (bv != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (bv != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      4'd5: m_hi = av;
      4'd6: m_lo = av;
      default: ;
    endcase
  endtask

  task automatic check_hilo(input string name);
    total++;
    if (hi !== m_hi || lo !== m_lo) begin
      bad++;
      $display("FAIL %s: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
    end
  endtask

  // Issue a multi-cycle op, count busy cycles, then compare HI/LO with the model.
  task automatic run_md(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input string name);
    int n;
    int expn;
    logic [31:0] old_lo;
    expn = (op <= 4'd2) ? MultN : DivN;
    old_lo = m_lo;
    @(posedge clk); #1;
    xaluop = op; start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; xaluop = 4'd8; a = $urandom; b = $urandom;
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (!busy) break;
      total++;
      if (xaluout !== old_lo) begin
        bad++;
        $display("FAIL %s mflo-while-busy: got %h, required %h", name, xaluout, old_lo);
      end
      n++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
    end
    total++;
    if (n != expn) begin
      bad++;
      $display("FAIL %s busy-length: got %0d, required %0d", name, n, expn);
    end
    model_exec(op, av, bv);
    check_hilo(name);
    xaluop = 4'd0;
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] av);
    @(posedge clk); #1;
    xaluop = op; start = 1'b1; a = av;
    @(posedge clk); #1;
    start = 1'b0; xaluop = 4'd0; a = $urandom;
    model_exec(op, av, 32'd0);
  endtask

  task automatic check_mf(input string name);
    @(posedge clk); #1;
    xaluop = 4'd7;
    @(negedge clk);
    total++;
    if (xaluout !== m_hi) begin
      bad++;
      $display("FAIL %s mfhi: got %h, required %h", name, xaluout, m_hi);
    end
    xaluop = 4'd8;
    #1;
    total++;
    if (xaluout !== m_lo) begin
      bad++;
      $display("FAIL %s mflo: got %h, required %h", name, xaluout, m_lo);
    end
    xaluop = 4'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    m_hi = '0; m_lo = '0;
    check_hilo("reset");
    total++;
    if (busy !== 1'b0 || xaluout !== 32'd0) begin
      bad++;
      $display("FAIL reset busy/xaluout: got %b/%h, required 0/0", busy, xaluout);
    end
  endtask

  task automatic test_directed;
    run_md(4'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    run_md(4'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_md(4'd4, 32'd7, 32'd2, "divu");
    do_mt(4'd5, 32'h11);
    do_mt(4'd6, 32'h22);
    run_md(4'd3, 32'd99, 32'd0, "div_by_zero");
    run_md(4'd4, 32'd99, 32'd0, "divu_by_zero");
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    total++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      bad++;
      $display("FAIL div_overflow const: hi=%h lo=%h, required 0/80000000", hi, lo);
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    @(posedge clk); #1;
    xaluop = 4'd1; start = 1'b1; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    xaluop = 4'd1; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    xaluop = 4'd6; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    xaluop = 4'd5; a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0; xaluop = 4'd0;
    n = 3;
    while (n < 64) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (n != MultN) begin
      bad++;
      $display("FAIL busy_ignore length: got %0d, required %0d", n, MultN);
    end
    model_exec(4'd1, 32'd1000, 32'd7);
    check_hilo("busy_ignore");
  endtask

  task automatic test_mt_mf;
    do_mt(4'd5, 32'h1234_5678);
    check_mf("mthi_mfhi");
    do_mt(4'd6, 32'h9ABC_DEF0);
    check_mf("mtlo_mflo");
    // start=0: nothing written or started regardless of xaluop
    @(posedge clk); #1;
    start = 1'b0; xaluop = 4'd5; a = 32'h5555_5555;
    @(posedge clk); #1;
    xaluop = 4'd3; b = 32'd3;
    @(posedge clk); #1;
    xaluop = 4'd11;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || xaluout !== 32'd0) begin
      bad++;
      $display("FAIL start0 busy/xaluout: got %b/%h, required 0/0", busy, xaluout);
    end
    check_hilo("start0");
    xaluop = 4'd0;
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [31:0] av, bv;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 6));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 5))
        0: bv = 32'd0;
        1: bv = 32'($urandom_range(1, 9));
        2: av = 32'h8000_0000;
        default: ;
      endcase
      if (op >= 4'd5) begin
        do_mt(op, av);
        check_mf("rand_mt");
      end else begin
        run_md(op, av, bv, "rand_md");
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_mt(4'd5, 32'hAAAA_0001);
    do_mt(4'd6, 32'hBBBB_0002);
    @(posedge clk); #1;
    xaluop = 4'd1; start = 1'b1; a = 32'd123; b = 32'd456;
    @(posedge clk); #1;
    start = 1'b0; xaluop = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid busy: got %b, required 0", busy);
    end
    check_hilo("reset_mid");
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL reset_mid late write: %0d bad cycles, required 0", n);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_mt_mf();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
